// File: rtl/toy_bus_core_slv_node.sv
// Core-to-bus slave node: registers LSU requests with source/target IDs,
// bounds outstanding transactions by credit and passes acks straight through.
module toy_bus_core_slv_node #(
    parameter int                       DATA_W       = 256,
    parameter logic [3:0]               SRC_ID       = 4'd1,
    parameter int                       NUM_REGION   = 2,
    parameter logic [NUM_REGION*32-1:0] REGION_BASE  = {32'hA000_0000, 32'h8000_0000},
    parameter logic [NUM_REGION*32-1:0] REGION_LIMIT = {32'hC000_0000, 32'hA000_0000},
    parameter logic [NUM_REGION*4-1:0]  REGION_TGT   = {4'd3, 4'd2},
    parameter logic [3:0]               DEFAULT_TGT  = 4'd4,
    parameter int                       MAX_OST      = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in0_req_vld,
    output logic                  in0_req_rdy,
    input  logic [31:0]           in0_req_addr,
    input  logic [DATA_W-1:0]     in0_req_data,
    input  logic [DATA_W/8-1:0]   in0_req_strb,
    input  logic                  in0_req_opcode,
    input  logic [31:0]           in0_req_sideband,
    output logic                  in0_ack_vld,
    input  logic                  in0_ack_rdy,
    output logic [DATA_W-1:0]     in0_ack_data,
    output logic [31:0]           in0_ack_sideband,
    output logic                  out0_req_vld,
    input  logic                  out0_req_rdy,
    output logic [31:0]           out0_req_addr,
    output logic [DATA_W/8-1:0]   out0_req_strb,
    output logic [DATA_W-1:0]     out0_req_data,
    output logic                  out0_req_opcode,
    output logic [3:0]            out0_req_src_id,
    output logic [3:0]            out0_req_tgt_id,
    output logic [31:0]           out0_req_sideband,
    input  logic                  out0_ack_vld,
    output logic                  out0_ack_rdy,
    input  logic [DATA_W-1:0]     out0_ack_data,
    input  logic [31:0]           out0_ack_sideband,
    input  logic [3:0]            out0_ack_tgt_id,
    output logic [3:0]            ost_cnt,
    output logic                  err_ack
);

    localparam logic [3:0] MAX_OST_C = 4'(MAX_OST);

    logic                r_vld;
    logic [31:0]         r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_strb;
    logic                r_opcode;
    logic [3:0]          r_tgt;
    logic [31:0]         r_sideband;
    logic [3:0]          r_ost;
    logic                r_err;

    logic                w_in_fire;
    logic                w_out_fire;
    logic                w_ack_fire;
    logic [3:0]          w_tgt;

    assign in0_req_rdy = (!r_vld || out0_req_rdy) && (r_ost < MAX_OST_C);
    assign w_in_fire   = in0_req_vld && in0_req_rdy;
    assign w_out_fire  = r_vld && out0_req_rdy;
    assign w_ack_fire  = out0_ack_vld && in0_ack_rdy;

    // Scan from the top index down so the lowest matching region overrides.
    always_comb begin
        w_tgt = DEFAULT_TGT;
        for (int i = NUM_REGION - 1; i >= 0; i--) begin
            if ((in0_req_addr >= REGION_BASE[i*32 +: 32]) &&
                (in0_req_addr <  REGION_LIMIT[i*32 +: 32])) begin
                w_tgt = REGION_TGT[i*4 +: 4];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_vld      <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_strb     <= '0;
            r_opcode   <= 1'b0;
            r_tgt      <= '0;
            r_sideband <= '0;
        end else if (w_in_fire) begin
            r_vld      <= 1'b1;
            r_addr     <= in0_req_addr;
            r_data     <= in0_req_data;
            r_strb     <= in0_req_strb;
            r_opcode   <= in0_req_opcode;
            r_tgt      <= w_tgt;
            r_sideband <= in0_req_sideband;
        end else if (w_out_fire) begin
            r_vld      <= 1'b0;
        end
    end

    // An ack with nothing outstanding is an error and must not wrap the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ost <= '0;
            r_err <= 1'b0;
        end else begin
            if (w_in_fire && !w_ack_fire) begin
                r_ost <= r_ost + 4'd1;
            end else if (!w_in_fire && w_ack_fire && (r_ost != 4'd0)) begin
                r_ost <= r_ost - 4'd1;
            end
            if (w_ack_fire && (((r_ost == 4'd0) && !w_in_fire) || (out0_ack_tgt_id != SRC_ID))) begin
                r_err <= 1'b1;
            end
        end
    end

    assign out0_req_vld      = r_vld;
    assign out0_req_addr     = r_addr;
    assign out0_req_data     = r_data;
    assign out0_req_strb     = r_strb;
    assign out0_req_opcode   = r_opcode;
    assign out0_req_tgt_id   = r_tgt;
    assign out0_req_sideband = r_sideband;
    assign out0_req_src_id   = SRC_ID;

    assign in0_ack_vld      = out0_ack_vld;
    assign in0_ack_data     = out0_ack_data;
    assign in0_ack_sideband = out0_ack_sideband;
    assign out0_ack_rdy     = in0_ack_rdy;

    assign ost_cnt = r_ost;
    assign err_ack = r_err;

endmodule

// File: tb/tb_toy_bus_core_slv_node.sv
// Directed bench for toy_bus_core_slv_node: decode table plus credit,
// backpressure, ack-error and reset sequences.
module tb_toy_bus_core_slv_node;

    localparam int DATA_W = 256;

    logic                clk;
    logic                rst;
    logic                in0_req_vld;
    logic                in0_req_rdy;
    logic [31:0]         in0_req_addr;
    logic [DATA_W-1:0]   in0_req_data;
    logic [DATA_W/8-1:0] in0_req_strb;
    logic                in0_req_opcode;
    logic [31:0]         in0_req_sideband;
    logic                in0_ack_vld;
    logic                in0_ack_rdy;
    logic [DATA_W-1:0]   in0_ack_data;
    logic [31:0]         in0_ack_sideband;
    logic                out0_req_vld;
    logic                out0_req_rdy;
    logic [31:0]         out0_req_addr;
    logic [DATA_W/8-1:0] out0_req_strb;
    logic [DATA_W-1:0]   out0_req_data;
    logic                out0_req_opcode;
    logic [3:0]          out0_req_src_id;
    logic [3:0]          out0_req_tgt_id;
    logic [31:0]         out0_req_sideband;
    logic                out0_ack_vld;
    logic                out0_ack_rdy;
    logic [DATA_W-1:0]   out0_ack_data;
    logic [31:0]         out0_ack_sideband;
    logic [3:0]          out0_ack_tgt_id;
    logic [3:0]          ost_cnt;
    logic                err_ack;

    int total = 0;
    int bad   = 0;

    toy_bus_core_slv_node dut (
        .clk(clk), .rst(rst),
        .in0_req_vld(in0_req_vld), .in0_req_rdy(in0_req_rdy),
        .in0_req_addr(in0_req_addr), .in0_req_data(in0_req_data),
        .in0_req_strb(in0_req_strb), .in0_req_opcode(in0_req_opcode),
        .in0_req_sideband(in0_req_sideband),
        .in0_ack_vld(in0_ack_vld), .in0_ack_rdy(in0_ack_rdy),
        .in0_ack_data(in0_ack_data), .in0_ack_sideband(in0_ack_sideband),
        .out0_req_vld(out0_req_vld), .out0_req_rdy(out0_req_rdy),
        .out0_req_addr(out0_req_addr), .out0_req_strb(out0_req_strb),
        .out0_req_data(out0_req_data), .out0_req_opcode(out0_req_opcode),
        .out0_req_src_id(out0_req_src_id), .out0_req_tgt_id(out0_req_tgt_id),
        .out0_req_sideband(out0_req_sideband),
        .out0_ack_vld(out0_ack_vld), .out0_ack_rdy(out0_ack_rdy),
        .out0_ack_data(out0_ack_data), .out0_ack_sideband(out0_ack_sideband),
        .out0_ack_tgt_id(out0_ack_tgt_id),
        .ost_cnt(ost_cnt), .err_ack(err_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  expTgt;
    } vec_t;

    vec_t vecs[6];

    function automatic logic [DATA_W-1:0] dataOf(input logic [31:0] a);
        return {8{a ^ 32'h5A5A_5A5A}};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic checkData(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h", name, act[63:0], exp[63:0]);
        end
    endtask

    // Request payload is derived from the address so every field is traceable.
    task automatic applyStimulus(input logic vld, input logic [31:0] addr,
                                 input logic ackVld, input logic [3:0] ackTgt);
        in0_req_vld      = vld;
        in0_req_addr     = addr;
        in0_req_data     = dataOf(addr);
        in0_req_strb     = {addr, ~addr};
        in0_req_opcode   = addr[4];
        in0_req_sideband = ~addr;
        out0_ack_vld     = ackVld;
        out0_ack_tgt_id  = ackTgt;
        in0_ack_rdy      = 1'b1;
    endtask

    task automatic checkReq(input string tag, input logic [31:0] addr, input logic [3:0] tgt);
        checkOutput({tag, "_vld"}, 32'(out0_req_vld), 1);
        checkOutput({tag, "_addr"}, out0_req_addr, addr);
        checkOutput({tag, "_tgt"}, 32'(out0_req_tgt_id), 32'(tgt));
        checkData({tag, "_data"}, out0_req_data, dataOf(addr));
        checkOutput({tag, "_sb"}, out0_req_sideband, ~addr);
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h8000_0010, 4'd2};
        vecs[1] = '{32'hA000_0000, 4'd3};
        vecs[2] = '{32'hC000_0000, 4'd4};
        vecs[3] = '{32'h7FFF_FFFC, 4'd4};
        vecs[4] = '{32'h9FFF_FFFF, 4'd2};
        vecs[5] = '{32'hBFFF_FFFF, 4'd3};

        out0_req_rdy      = 1'b1;
        out0_ack_data     = {8{32'hDEAD_BEEF}};
        out0_ack_sideband = 32'h1234_5678;
        doReset();

        // Reset state and ack passthrough while reset is asserted.
        rst = 1'b1;
        applyStimulus(1'b1, 32'h8000_0000, 1'b1, 4'd1);
        #1;
        checkOutput("rst_ack_vld", 32'(in0_ack_vld), 1);
        checkData("rst_ack_data", in0_ack_data, {8{32'hDEAD_BEEF}});
        checkOutput("rst_ack_sb", in0_ack_sideband, 32'h1234_5678);
        in0_ack_rdy = 1'b0;
        #1;
        checkOutput("rst_ack_rdy", 32'(out0_ack_rdy), 0);
        step();
        checkOutput("rst_vld", 32'(out0_req_vld), 0);
        checkOutput("rst_addr", out0_req_addr, 0);
        checkOutput("rst_tgt", 32'(out0_req_tgt_id), 0);
        checkOutput("rst_ost", 32'(ost_cnt), 0);
        checkOutput("rst_err", 32'(err_ack), 0);
        checkOutput("rst_src", 32'(out0_req_src_id), 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        rst = 1'b0;
        step();

        // Address decode table, one accept then one ack per vector.
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, vecs[i].addr, 1'b0, 4'd1);
            step();
            checkReq("dec", vecs[i].addr, vecs[i].expTgt);
            checkOutput("dec_src", 32'(out0_req_src_id), 1);
            checkOutput("dec_ost", 32'(ost_cnt), 1);
            applyStimulus(1'b0, 32'h0, 1'b1, 4'd1);
            step();
            checkOutput("dec_drain_ost", 32'(ost_cnt), 0);
            checkOutput("dec_drain_vld", 32'(out0_req_vld), 0);
        end
        checkOutput("dec_err", 32'(err_ack), 0);

        // Credit limit: four accepts with acks withheld.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h8000_0100 + 32'(i * 4), 1'b0, 4'd1);
            step();
        end
        checkOutput("cred_ost4", 32'(ost_cnt), 4);
        checkOutput("cred_rdy0", 32'(in0_req_rdy), 0);
        step();
        checkOutput("cred_hold_ost", 32'(ost_cnt), 4);
        applyStimulus(1'b1, 32'h8000_0200, 1'b1, 4'd1);
        step();
        checkOutput("cred_ost3", 32'(ost_cnt), 3);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        #1;
        checkOutput("cred_rdy1", 32'(in0_req_rdy), 1);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'd1);
        step();
        step();
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        checkOutput("cred_drain", 32'(ost_cnt), 0);

        // Backpressure: held payload must not change, then drain 1/cycle.
        out0_req_rdy = 1'b0;
        applyStimulus(1'b1, 32'h8000_1000, 1'b0, 4'd1);
        step();
        applyStimulus(1'b1, 32'hA000_2000, 1'b0, 4'd1);
        for (int i = 0; i < 5; i++) begin
            #1;
            checkOutput("bp_rdy", 32'(in0_req_rdy), 0);
            checkReq("bp_hold", 32'h8000_1000, 4'd2);
            step();
        end
        out0_req_rdy = 1'b1;
        step();
        checkReq("bp_a2", 32'hA000_2000, 4'd3);
        applyStimulus(1'b1, 32'hC000_3000, 1'b0, 4'd1);
        step();
        checkReq("bp_a3", 32'hC000_3000, 4'd4);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        step();
        checkOutput("bp_clear", 32'(out0_req_vld), 0);
        checkOutput("bp_ost", 32'(ost_cnt), 3);
        applyStimulus(1'b0, 32'h0, 1'b1, 4'd1);
        step();
        step();
        step();
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        checkOutput("bp_drain", 32'(ost_cnt), 0);
        checkOutput("bp_err", 32'(err_ack), 0);

        // Underflow ack: sticky error, counter pinned at zero.
        applyStimulus(1'b0, 32'h0, 1'b1, 4'd1);
        step();
        checkOutput("uf_err", 32'(err_ack), 1);
        checkOutput("uf_ost", 32'(ost_cnt), 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        step();
        step();
        checkOutput("uf_sticky", 32'(err_ack), 1);
        doReset();
        checkOutput("uf_rst_err", 32'(err_ack), 0);

        // Misrouted ack still consumes a credit.
        applyStimulus(1'b1, 32'h8000_0040, 1'b0, 4'd1);
        step();
        applyStimulus(1'b0, 32'h0, 1'b1, 4'd5);
        step();
        checkOutput("mr_err", 32'(err_ack), 1);
        checkOutput("mr_ost", 32'(ost_cnt), 0);
        doReset();

        // Concurrent accept and ack at ost=2.
        applyStimulus(1'b1, 32'h8000_0050, 1'b0, 4'd1);
        step();
        step();
        checkOutput("sim_ost2", 32'(ost_cnt), 2);
        applyStimulus(1'b1, 32'h8000_0060, 1'b1, 4'd1);
        step();
        checkOutput("sim_ost", 32'(ost_cnt), 2);
        checkOutput("sim_err", 32'(err_ack), 0);
        checkReq("sim_req", 32'h8000_0060, 4'd2);

        // Reset mid-operation discards the held request.
        out0_req_rdy = 1'b0;
        applyStimulus(1'b1, 32'hA000_0070, 1'b0, 4'd5);
        step();
        rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b0, 4'd1);
        step();
        rst = 1'b0;
        checkOutput("mid_vld", 32'(out0_req_vld), 0);
        checkOutput("mid_addr", out0_req_addr, 0);
        checkOutput("mid_tgt", 32'(out0_req_tgt_id), 0);
        checkOutput("mid_ost", 32'(ost_cnt), 0);
        checkOutput("mid_err", 32'(err_ack), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/toy_bus_core_slv_node.md
Name:
toy_bus_core_slv_node
Overview:
Parametrised core-to-bus slave node that registers LSU requests, stamps a fixed source ID and an address-decoded target ID onto each one, and limits outstanding transactions with a credit counter. The ack path passes straight through; a sticky error flags unexpected or misrouted acks. Sits between a core port and the bus network, one instance per core-side requester.
Parameters:
DATA_W, 256, req/ack data width; strb width = DATA_W/8
SRC_ID, 4'd1, constant driven on out0_req_src_id and expected on out0_ack_tgt_id
NUM_REGION, 2, number of address-map regions (1..8)
REGION_BASE, {32'hA000_0000,32'h8000_0000}, packed NUM_REGION*32, inclusive base, region i at [i*32+:32]
REGION_LIMIT, {32'hC000_0000,32'hA000_0000}, packed NUM_REGION*32, exclusive limit
REGION_TGT, {4'd3,4'd2}, packed NUM_REGION*4 target IDs
DEFAULT_TGT, 4'd4, target ID when no region hits
MAX_OST, 4, max outstanding requests (1..15); counter width 4
Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
in0_req_vld  in  1  core request valid
in0_req_rdy  out  1  core request ready
in0_req_addr  in  32  request address
in0_req_data  in  DATA_W  write data
in0_req_strb  in  DATA_W/8  byte strobes
in0_req_opcode  in  1  opcode
in0_req_sideband  in  32  sideband
in0_ack_vld  out  1  ack valid to core
in0_ack_rdy  in  1  core ack ready
in0_ack_data  out  DATA_W  ack data
in0_ack_sideband  out  32  ack sideband
out0_req_vld  out  1  bus request valid (registered)
out0_req_rdy  in  1  bus request ready
out0_req_addr  out  32  registered address
out0_req_strb  out  DATA_W/8  registered strobes
out0_req_data  out  DATA_W  registered data
out0_req_opcode  out  1  registered opcode
out0_req_src_id  out  4  constant SRC_ID
out0_req_tgt_id  out  4  registered decoded target
out0_req_sideband  out  32  registered sideband
out0_ack_vld  in  1  bus ack valid
out0_ack_rdy  out  1  bus ack ready
out0_ack_data  in  DATA_W  bus ack data
out0_ack_sideband  in  32  bus ack sideband
out0_ack_tgt_id  in  4  ack destination ID, checked against SRC_ID
ost_cnt  out  4  current outstanding count
err_ack  out  1  sticky ack error
Behaviour:
- Req stage: one-entry register. in0_req_rdy = (!out0_req_vld | out0_req_rdy) & (ost_cnt < MAX_OST). On in0 fire, load payload and decoded tgt into the register and set out0_req_vld next cycle; latency is 1 cycle; throughput is 1 req/cycle under continuous out0_req_rdy. Payload is held stable while out0_req_vld & !out0_req_rdy. out0_req_vld clears after an out0 fire with no concurrent in0 fire.
- Decode, combinational on in0_req_addr: the lowest-index region with BASE <= addr < LIMIT (unsigned) wins; no hit gives DEFAULT_TGT. Region with BASE >= LIMIT never hits.
- ost_cnt: +1 on in0 req fire, -1 on ack fire (out0_ack_vld & out0_ack_rdy). Both fires in the same cycle leave it unchanged. Never exceeds MAX_OST; never goes below 0.
- Ack path is combinational passthrough: in0_ack_vld = out0_ack_vld, data and sideband pass through, out0_ack_rdy = in0_ack_rdy. No added latency.
- err_ack is set on an ack fire with (ost_cnt == 0 and no concurrent req fire), or with out0_ack_tgt_id != SRC_ID. An underflow ack leaves ost_cnt at 0. A misrouted ack still decrements ost_cnt. err_ack clears only on rst.
- Reset: out0_req_vld, all out0_req payload registers, out0_req_tgt_id, ost_cnt and err_ack = 0. out0_req_src_id = SRC_ID always. Ack outputs follow their inputs during reset.
- Reset mid-operation discards the held request. Acks for requests issued before reset set err_ack, so the system drains before asserting rst.
Test Plan:
- Default map: addr 0x8000_0010 gives tgt 2; 0xA000_0000 gives 3; 0xC000_0000 gives 4; 0x7FFF_FFFC gives 4. Each appears on out0 one cycle after accept, with src_id 1.
- MAX_OST=4, acks withheld: 4 accepts, then in0_req_rdy=0 and ost_cnt=4. Issue one ack: in0_req_rdy=1 the following cycle, ost_cnt=3.
- out0_req_rdy=0 for 5 cycles: out0_req_vld and payload stay stable, in0_req_rdy=0. Release: back-to-back reqs go out 1/cycle, no loss or duplication.
- Ack at ost_cnt=0 gives err_ack=1 (sticky), ost_cnt stays 0. Ack with tgt_id=5 gives err_ack=1. Simultaneous accept and ack at ost_cnt=2 leaves it at 2. rst clears all state.
